// File: rtl/uart_frame_parser.sv
// uart_frame_parser
//
// Parses length-prefixed frames from a UART receiver byte stream:
//   SOF, LEN, LEN payload bytes, CHK   where CHK = LEN ^ payload[0] ^ ... ^ payload[LEN-1]
// Payload is written speculatively into a FIFO. It is only made visible on the
// output stream once the checksum matches. Bad frames are rolled back and reported.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   rx_data    byte from the UART receiver
//   rx_ready   receiver data_ready level; a byte is taken on its rising edge
//   m_data     payload byte (valid/ready stream)
//   m_valid    m_data/m_last valid
//   m_ready    downstream accepts; transfer when m_valid && m_ready
//   m_last     final payload byte of a frame
//   frame_ok   one-cycle pulse: frame committed
//   frame_err  one-cycle pulse: frame discarded
//   err_code   cause of last frame_err: 0 timeout, 1 bad length, 2 checksum, 3 no FIFO space
module uart_frame_parser #(
    parameter logic [7:0] SOF_BYTE       = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         FIFO_DEPTH     = 32,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [1:0] ST_HUNT    = 2'd0;
    localparam logic [1:0] ST_LEN     = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
    localparam logic [1:0] ST_CHK     = 2'd3;

    localparam logic [1:0] ERR_TIMEOUT = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CHK     = 2'd2;
    localparam logic [1:0] ERR_SPACE   = 2'd3;

    localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);
    localparam logic [TW-1:0] CNT_ONE = TW'(1);
    localparam logic [TW-1:0] CNT_MAX = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    state;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   wr_commit;
    logic [AW:0]   wr_spec;
    logic          rx_ready_d;
    logic [TW-1:0] idle_cnt;
    logic [7:0]    remaining;
    logic [7:0]    xor_acc;
    logic [8:0]    mem [FIFO_DEPTH];

    logic          accept;
    logic          timeout;
    logic          xfer;
    logic [AW:0]   occupancy;
    logic [8:0]    free_space;

    assign accept     = rx_ready & ~rx_ready_d;
    // An accept in the same cycle resets the idle gap, so it wins over timeout.
    assign timeout    = (state != ST_HUNT) && !accept && (idle_cnt == CNT_MAX);
    assign occupancy  = wr_commit - rd_ptr;
    assign free_space = 9'(FIFO_DEPTH) - 9'(occupancy);

    // Fall-through read: the head entry is only exposed once committed.
    assign m_valid = (rd_ptr != wr_commit);
    assign xfer    = m_valid & m_ready;
    assign m_data  = m_valid ? mem[rd_ptr[AW-1:0]][7:0] : 8'h00;
    assign m_last  = m_valid & mem[rd_ptr[AW-1:0]][8];

    // Control: FSM, pointers, timeout counter and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_HUNT;
            rd_ptr     <= '0;
            wr_commit  <= '0;
            wr_spec    <= '0;
            rx_ready_d <= 1'b0;
            idle_cnt   <= '0;
            frame_ok   <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= ERR_TIMEOUT;
        end else begin
            rx_ready_d <= rx_ready;
            frame_ok   <= 1'b0;
            frame_err  <= 1'b0;

            if (xfer) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end

            if (accept || state == ST_HUNT) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + CNT_ONE;
            end

            if (timeout) begin
                wr_spec   <= wr_commit;
                frame_err <= 1'b1;
                err_code  <= ERR_TIMEOUT;
                state     <= ST_HUNT;
            end else if (accept) begin
                case (state)
                    ST_HUNT: begin
                        if (rx_data == SOF_BYTE) begin
                            state <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (rx_data == 8'd0 || rx_data > 8'(MAX_LEN)) begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_LEN;
                            state     <= ST_HUNT;
                        end else if ({1'b0, rx_data} > free_space) begin
                            // Space is only checked here; reads during the
                            // frame can only free more entries.
                            frame_err <= 1'b1;
                            err_code  <= ERR_SPACE;
                            state     <= ST_HUNT;
                        end else begin
                            state <= ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        wr_spec <= wr_spec + PTR_ONE;
                        if (remaining == 8'd1) begin
                            state <= ST_CHK;
                        end
                    end
                    ST_CHK: begin
                        if (rx_data == xor_acc) begin
                            wr_commit <= wr_spec;
                            frame_ok  <= 1'b1;
                        end else begin
                            wr_spec   <= wr_commit;
                            frame_err <= 1'b1;
                            err_code  <= ERR_CHK;
                        end
                        state <= ST_HUNT;
                    end
                    default: state <= ST_HUNT;
                endcase
            end
        end
    end

    // Datapath: remaining count, running checksum and payload storage.
    // Loaded unconditionally at LEN; the FSM decides whether they are used.
    always_ff @(posedge clk) begin
        if (accept && state == ST_LEN) begin
            remaining <= rx_data;
            xor_acc   <= rx_data;
        end
        if (accept && state == ST_PAYLOAD) begin
            mem[wr_spec[AW-1:0]] <= {remaining == 8'd1, rx_data};
            remaining            <= remaining - 8'd1;
            xor_acc              <= xor_acc ^ rx_data;
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser
//
// Randomised and directed byte streams are fed to uart_frame_parser. A
// frame-level reference model collects bytes into a queue and judges whole
// frames (length limits, free space, XOR over the collected bytes, idle gap).
// It predicts committed payload, status pulses and err_code.
//
// Ports: none (top-level bench).
module tb_uart_frame_parser;

    localparam logic [7:0] SOF   = 8'hA5;
    localparam int         MAXL  = 16;
    localparam int         DEPTH = 32;
    localparam int         TMO   = 300;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;

    uart_frame_parser #(
        .SOF_BYTE(SOF),
        .MAX_LEN(MAXL),
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_data(rx_data),
        .rx_ready(rx_ready),
        .m_data(m_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_last(m_last),
        .frame_ok(frame_ok),
        .frame_err(frame_err),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    logic [7:0] cur[$];       // bytes of the frame being collected (from SOF)
    logic [8:0] exp_out[$];   // committed {last, data} not yet transferred
    logic [1:0] exp_code = 2'd0;
    logic [1:0] pend_code = 2'd0;
    bit         pend_ok = 1'b0;
    bit         pend_err = 1'b0;
    bit         prev_ready = 1'b0;
    bit         model_on = 1'b0;
    int         cyc = 0;
    int         last_acc = 0;
    int         ok_seen = 0;
    int         err_seen[4] = '{0, 0, 0, 0};
    int         rdy_mode = 0;
    int         occ_now;
    logic [8:0] head;

    task automatic raise_err(input logic [1:0] code);
        pend_err  = 1'b1;
        pend_code = code;
    endtask

    task automatic model_byte(input logic [7:0] b, input int occ);
        int         len;
        logic [7:0] x;
        if (cur.size() == 0) begin
            if (b == SOF) cur.push_back(b);
        end else if (cur.size() == 1) begin
            len = int'(b);
            if (len == 0 || len > MAXL) raise_err(2'd1);
            else if (len > DEPTH - occ) raise_err(2'd3);
            else cur.push_back(b);
            if (cur.size() == 1) cur.delete();
        end else begin
            cur.push_back(b);
            len = int'(cur[1]);
            if (cur.size() == len + 3) begin
                x = 8'h00;
                for (int i = 1; i < cur.size() - 1; i++) x ^= cur[i];
                if (x == b) begin
                    for (int i = 2; i < cur.size() - 1; i++)
                        exp_out.push_back({i == cur.size() - 2, cur[i]});
                    pend_ok = 1'b1;
                end else begin
                    raise_err(2'd2);
                end
                cur.delete();
            end
        end
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            cyc++;
            check_val("m_valid", 32'(m_valid), 32'(exp_out.size() != 0));
            check_val("frame_ok", 32'(frame_ok), 32'(pend_ok));
            check_val("frame_err", 32'(frame_err), 32'(pend_err));
            if (pend_err) exp_code = pend_code;
            check_val("err_code", 32'(err_code), 32'(exp_code));
            if (frame_ok) ok_seen++;
            if (frame_err) err_seen[err_code]++;
            pend_ok  = 1'b0;
            pend_err = 1'b0;
            occ_now  = exp_out.size();
            if (m_valid && m_ready) begin
                check_val("xfer_avail", 32'(exp_out.size() != 0), 32'd1);
                if (exp_out.size() != 0) begin
                    head = exp_out.pop_front();
                    check_val("m_data", 32'(m_data), 32'(head[7:0]));
                    check_val("m_last", 32'(m_last), 32'(head[8]));
                end
            end
            if (reset) begin
                cur.delete();
                exp_out.delete();
                exp_code   = 2'd0;
                prev_ready = 1'b0;
            end else begin
                if (rx_ready && !prev_ready) begin
                    last_acc = cyc;
                    model_byte(rx_data, occ_now);
                end else if (cur.size() != 0 && cyc - last_acc == TMO) begin
                    cur.delete();
                    raise_err(2'd0);
                end
                prev_ready = rx_ready;
            end
        end
    end

    // Downstream ready: 0 always ready, 1 stalled, other random
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: m_ready = 1'b1;
                1: m_ready = 1'b0;
                default: m_ready = ($urandom % 4) != 0;
            endcase
        end
    end

    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_ready = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        rx_ready = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic send_rb(input logic [7:0] b);
        send_byte(b, 1 + int'($urandom % 3), int'($urandom % 4));
    endtask

    task automatic send_frame(input int len, input bit good);
        logic [7:0] x;
        logic [7:0] p;
        logic [7:0] flip;
        x = 8'(len);
        send_rb(SOF);
        send_rb(8'(len));
        for (int i = 0; i < len; i++) begin
            p = 8'($urandom);
            if ($urandom % 10 == 0) p = SOF;
            x ^= p;
            send_rb(p);
        end
        flip = 8'h01 << ($urandom % 8);
        send_rb(good ? x : (x ^ flip));
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_out.size() != 0 || m_valid) && t < 3000) begin
            @(posedge clk);
            t++;
        end
        check_val("drain_done", 32'(t < 3000), 32'd1);
        repeat (3) @(posedge clk);
    endtask

    function automatic int err_total();
        return err_seen[0] + err_seen[1] + err_seen[2] + err_seen[3];
    endfunction

    initial begin
        int         ok0;
        int         et0;
        int         e0;
        int         len;
        int         k;
        logic [7:0] b;

        reset    = 1'b1;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_val("rst_m_valid", 32'(m_valid), 32'd0);
        check_val("rst_m_last", 32'(m_last), 32'd0);
        check_val("rst_m_data", 32'(m_data), 32'd0);
        check_val("rst_frame_ok", 32'(frame_ok), 32'd0);
        check_val("rst_frame_err", 32'(frame_err), 32'd0);
        check_val("rst_err_code", 32'(err_code), 32'd0);
        model_on = 1'b1;

        // Basic good frame
        rdy_mode = 0;
        ok0 = ok_seen; et0 = err_total();
        send_rb(8'hA5); send_rb(8'h03); send_rb(8'h11);
        send_rb(8'h22); send_rb(8'h33); send_rb(8'h03);
        repeat (10) @(posedge clk);
        check_val("t1_ok", ok_seen - ok0, 1);
        check_val("t1_err", err_total() - et0, 0);

        // Bad checksum then good one-byte frame
        ok0 = ok_seen; e0 = err_seen[2];
        send_rb(8'hA5); send_rb(8'h02); send_rb(8'h10); send_rb(8'h20); send_rb(8'hFF);
        send_rb(8'hA5); send_rb(8'h01); send_rb(8'h7E); send_rb(8'h7F);
        repeat (10) @(posedge clk);
        check_val("t2_err_chk", err_seen[2] - e0, 1);
        check_val("t2_ok", ok_seen - ok0, 1);

        // Bad lengths, junk, then good frame
        ok0 = ok_seen; e0 = err_seen[1];
        send_rb(8'hA5); send_rb(8'h00);
        send_rb(8'hA5); send_rb(8'h11);
        send_rb(8'h00); send_rb(8'hFF);
        send_frame(5, 1'b1);
        repeat (10) @(posedge clk);
        check_val("t3_err_len", err_seen[1] - e0, 2);
        check_val("t3_ok", ok_seen - ok0, 1);

        // Fill the FIFO, then overflow attempt, drain, retry
        wait_drain();
        rdy_mode = 1;
        ok0 = ok_seen; e0 = err_seen[3];
        send_frame(16, 1'b1);
        send_frame(16, 1'b1);
        send_rb(8'hA5); send_rb(8'h01);
        repeat (5) @(posedge clk);
        check_val("t4_ok_full", ok_seen - ok0, 2);
        check_val("t4_err_space", err_seen[3] - e0, 1);
        rdy_mode = 0;
        wait_drain();
        ok0 = ok_seen;
        send_frame(1, 1'b1);
        repeat (10) @(posedge clk);
        check_val("t4_retry_ok", ok_seen - ok0, 1);

        // Timeout mid-payload
        ok0 = ok_seen; e0 = err_seen[0];
        send_rb(8'hA5); send_rb(8'h04); send_rb(8'h01); send_rb(8'h02);
        repeat (TMO + 10) @(posedge clk);
        check_val("t5_err_tmo", err_seen[0] - e0, 1);
        check_val("t5_no_ok", ok_seen - ok0, 0);

        // rx_ready held high gives a single accept
        ok0 = ok_seen; et0 = err_total();
        send_byte(8'hA5, 50, 2);
        send_byte(8'h01, 1, 1);
        send_byte(8'h55, 50, 2);
        send_byte(8'h54, 1, 1);
        repeat (10) @(posedge clk);
        check_val("t6_hold_ok", ok_seen - ok0, 1);
        check_val("t6_hold_err", err_total() - et0, 0);

        // Reset mid-payload with committed data pending
        rdy_mode = 1;
        send_frame(3, 1'b1);
        send_rb(8'hA5); send_rb(8'h05); send_rb(8'h01); send_rb(8'h02);
        et0 = err_total();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_val("t7_rst_valid", 32'(m_valid), 32'd0);
        rdy_mode = 0;
        repeat (5) @(posedge clk);
        check_val("t7_rst_noerr", err_total() - et0, 0);
        ok0 = ok_seen;
        send_frame(4, 1'b1);
        repeat (10) @(posedge clk);
        check_val("t7_after_ok", ok_seen - ok0, 1);

        // Randomised traffic
        rdy_mode = 2;
        for (int n = 0; n < 200; n++) begin
            k = int'($urandom % 20);
            if (k == 0) begin
                b = 8'($urandom);
                if (b == SOF) b = 8'h00;
                send_rb(b);
            end else if (k == 1) begin
                send_rb(SOF);
                b = ($urandom % 2 == 0) ? 8'h00 : 8'(17 + $urandom % 239);
                send_rb(b);
            end else if (k == 2) begin
                send_frame(1 + int'($urandom % 16), 1'b0);
            end else if (k == 3) begin
                len = 2 + int'($urandom % 15);
                send_rb(SOF);
                send_rb(8'(len));
                for (int i = 0; i < int'($urandom % len); i++) send_rb(8'($urandom));
                repeat (TMO + 5) @(posedge clk);
            end else begin
                send_frame(1 + int'($urandom % 16), 1'b1);
            end
        end
        rdy_mode = 0;
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
